seq_mult_8: RTL and testbench

- Sequential 8x8 unsigned shift-add multiplier that produces a 16-bit product.
- Sits directly downstream of the 8-bit adder/subtractor datapath and reuses its add function iteratively, one partial-product add per clock.
- Serves as the ALU's multiply unit. Operands come from the ALU input muxes; the product goes to the ALU result mux.

---
 rtl/seq_mult_8.sv | 103 ++++++++++
 tb/tb_seq_mult_8.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_8.sv
// Sequential unsigned shift-add multiplier: W-bit x W-bit -> 2W-bit product.
// One partial-product add and one right shift per clock; W iterations per
// multiply. The product register only updates on completion or reset, so the
// downstream result mux never sees a partial value.
module seq_mult_8 #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [CntW-1:0] count_q, count_d;
    logic [2*W-1:0]  product_q, product_d;

    logic [W-1:0]    addend;
    logic [W:0]      sum;
    logic [2*W-1:0]  shifted;

    // One iteration of the datapath: conditional add into the upper half with the
    // carry kept, then shift right so the carry lands in the MSB.
    always_comb begin
        addend  = acc_q[0] ? mcand_q : '0;
        sum     = {1'b0, acc_q[2*W-1:W]} + {1'b0, addend};
        shifted = {sum, acc_q[W-1:1]};
    end

    // Next-state logic: accept start only in idle, iterate in run, pulse done.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = {{W{1'b0}}, b};
                    count_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d   = shifted;
                count_d = count_q + 1'b1;
                if (count_q == LastCnt) begin
                    product_d = shifted;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-high reset; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Outputs decode straight from registered state, so no input-to-output path.
    always_comb begin
        busy    = (state_q == StRun);
        done    = (state_q == StDone);
        product = product_q;
    end

endmodule

// File: tb/tb_seq_mult_8.sv
// Self-checking bench for seq_mult_8: a cycle-timer reference model built from
// the latency rules, compared every cycle, plus literal expectations per vector.
module tb_seq_mult_8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    seq_mult_8 #(.W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: m_age counts cycles since the accepting edge.
    // 0 = idle, 1..8 = busy, 9 = done cycle with product = a*b.
    int          m_age = 0;
    logic [15:0] m_pend = '0;
    logic [15:0] m_prod = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_age  = 0;
            m_prod = '0;
        end else if (m_age == 0) begin
            if (start) begin
                m_pend = 16'(a) * 16'(b);
                m_age  = 1;
            end
        end else if (m_age < 9) begin
            m_age++;
            if (m_age == 9) m_prod = m_pend;
        end else begin
            m_age = 0;
        end
    end

    // Compare DUT outputs against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_age >= 1 && m_age <= 8));
            check("done", 32'(done), 32'(m_age == 9));
            check("product", 32'(product), 32'(m_prod));
            check("busy_done_excl", 32'(busy & done), 32'd0);
        end
    end

    // Wait for done with a bound; returns negedges counted since the start edge.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: done never rose within %0d cycles", lat);
        end
    endtask

    // Pulse start for one edge, then check latency and the literal product.
    task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] exp);
        int lat;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~av;
        b = ~bv;
        wait_done(lat);
        check({name, "_latency"}, 32'(lat), 32'd9);
        check({name, "_product"}, 32'(product), 32'(exp));
        @(negedge clk);
        check({name, "_done_fell"}, 32'(done), 32'd0);
        check({name, "_hold"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int lat;

        // Reset with start held high: nothing may start.
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        a = 8'h12;
        b = 8'h34;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'h0000);
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);

        run_op("basic", 8'h0D, 8'h0B, 16'h008F);
        run_op("max", 8'hFF, 8'hFF, 16'hFE01);
        run_op("carry", 8'h80, 8'h02, 16'h0100);
        run_op("zero", 8'h00, 8'h5A, 16'h0000);
        run_op("ident", 8'h01, 8'hC3, 16'h00C3);
        run_op("mid", 8'hA5, 8'h3C, 16'h26AC);

        // Start held continuously; operands change mid-run.
        @(negedge clk);
        a = 8'd3;
        b = 8'd4;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a = 8'd9;
        b = 8'd9;
        lat = 2;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("hold_start_latency", 32'(lat), 32'd9);
        check("hold_start_product", 32'(product), 32'h000C);
        @(negedge clk);
        check("hold_start_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("hold_start_reaccept", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(lat);
        check("hold_start_second", 32'(product), 32'h0051);
        repeat (2) @(negedge clk);

        // Abort with reset sampled at the fourth edge after the start edge.
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'h0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        run_op("after_abort", 8'd2, 8'd3, 16'h0006);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
